// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: hazard arbitration, pending-redirect
// hold, mul/div wait and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  input  logic             E_mispredict,
  input  logic [XLEN-1:0]  E_redirect_pc,
  input  logic             E_is_load,
  input  logic [4:0]       E_rd,
  input  logic [4:0]       D_rs1,
  input  logic [4:0]       D_rs2,
  input  logic             D_uses_rs1,
  input  logic             D_uses_rs2,
  input  logic             E_md_start,
  input  logic             md_done,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic             fd_flush,
  output logic             de_stall,
  output logic             de_flush,
  output logic             em_stall,
  output logic             em_flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    REDIR  = 2'b01,
    MDWAIT = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic            load_use;
  logic            flush_inc;
  logic            pc_s, fd_s, fd_f, de_s, de_f, em_s, em_f, rv;
  logic [XLEN-1:0] rpc;

  assign load_use = E_is_load && (E_rd != 5'd0) &&
                    ((D_uses_rs1 && (D_rs1 == E_rd)) ||
                     (D_uses_rs2 && (D_rs2 == E_rd)));

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    flush_inc = 1'b0;
    pc_s      = 1'b0;
    fd_s      = 1'b0;
    fd_f      = 1'b0;
    de_s      = 1'b0;
    de_f      = 1'b0;
    em_s      = 1'b0;
    em_f      = 1'b0;
    rv        = 1'b0;
    rpc       = '0;
    unique case (state_q)
      RUN: begin
        if (dmem_wait) begin
          pc_s = 1'b1;
          fd_s = 1'b1;
          de_s = 1'b1;
          em_s = 1'b1;
        end else if (E_mispredict) begin
          fd_f      = 1'b1;
          de_f      = 1'b1;
          rv        = 1'b1;
          rpc       = E_redirect_pc;
          flush_inc = 1'b1;
          if (imem_wait) begin
            tgt_d   = E_redirect_pc;
            state_d = REDIR;
          end
        end else if (load_use) begin
          pc_s = 1'b1;
          fd_s = 1'b1;
          de_f = 1'b1;
        end else if (E_md_start && !md_done) begin
          pc_s    = 1'b1;
          fd_s    = 1'b1;
          de_s    = 1'b1;
          em_f    = 1'b1;
          state_d = MDWAIT;
        end else if (imem_wait) begin
          pc_s = 1'b1;
          fd_f = 1'b1;
        end
      end
      REDIR: begin
        fd_f = 1'b1;
        rv   = 1'b1;
        rpc  = tgt_q;
        // A newer EX redirect supersedes the pending one immediately.
        if (E_mispredict) begin
          tgt_d = E_redirect_pc;
          rpc   = E_redirect_pc;
        end
        if (dmem_wait) begin
          de_s = 1'b1;
          em_s = 1'b1;
        end
        if (!imem_wait) state_d = RUN;
      end
      MDWAIT: begin
        if (md_done) begin
          state_d = RUN;
        end else begin
          pc_s = 1'b1;
          fd_s = 1'b1;
          de_s = 1'b1;
          em_s = dmem_wait;
          em_f = !dmem_wait;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs forced low in reset; flush overrides stall on each register.
  assign pc_stall       = rst & pc_s;
  assign fd_flush       = rst & fd_f;
  assign fd_stall       = rst & fd_s & ~fd_f;
  assign de_flush       = rst & de_f;
  assign de_stall       = rst & de_s & ~de_f;
  assign em_flush       = rst & em_f;
  assign em_stall       = rst & em_s & ~em_f;
  assign redirect_valid = rst & rv;
  assign redirect_pc    = (rst && rv) ? rpc : '0;
  assign ctrl_state     = state_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (flush_inc && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      tgt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, redirect hold,
// priority, mul/div wait and counter saturation (4-bit instance).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_wait, dmem_wait, E_mispredict;
  logic [31:0] E_redirect_pc;
  logic        E_is_load;
  logic [4:0]  E_rd, D_rs1, D_rs2;
  logic        D_uses_rs1, D_uses_rs2, E_md_start, md_done;

  logic        pc_stall, fd_stall, fd_flush, de_stall;
  logic        de_flush, em_stall, em_flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  ctrl_state;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  logic        s_pc_stall, s_fd_stall, s_fd_flush, s_de_stall;
  logic        s_de_flush, s_em_stall, s_em_flush, s_redirect_valid;
  logic [31:0] s_redirect_pc;
  logic [1:0]  s_ctrl_state;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  logic [7:0]  ctl;
  assign ctl = {pc_stall, fd_stall, fd_flush, de_stall,
                de_flush, em_stall, em_flush, redirect_valid};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .E_mispredict(E_mispredict), .E_redirect_pc(E_redirect_pc),
    .E_is_load(E_is_load), .E_rd(E_rd),
    .D_rs1(D_rs1), .D_rs2(D_rs2),
    .D_uses_rs1(D_uses_rs1), .D_uses_rs2(D_uses_rs2),
    .E_md_start(E_md_start), .md_done(md_done),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush),
    .de_stall(de_stall), .de_flush(de_flush),
    .em_stall(em_stall), .em_flush(em_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ctrl_state(ctrl_state),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  pipe_hazard_ctrl #(.XLEN(32), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .E_mispredict(E_mispredict), .E_redirect_pc(E_redirect_pc),
    .E_is_load(E_is_load), .E_rd(E_rd),
    .D_rs1(D_rs1), .D_rs2(D_rs2),
    .D_uses_rs1(D_uses_rs1), .D_uses_rs2(D_uses_rs2),
    .E_md_start(E_md_start), .md_done(md_done),
    .pc_stall(s_pc_stall), .fd_stall(s_fd_stall), .fd_flush(s_fd_flush),
    .de_stall(s_de_stall), .de_flush(s_de_flush),
    .em_stall(s_em_stall), .em_flush(s_em_flush),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .ctrl_state(s_ctrl_state),
    .perf_stall_cnt(s_stall_cnt), .perf_flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    imem_wait = 0; dmem_wait = 0; E_mispredict = 0;
    E_redirect_pc = '0; E_is_load = 0; E_rd = '0;
    D_rs1 = '0; D_rs2 = '0; D_uses_rs1 = 0; D_uses_rs2 = 0;
    E_md_start = 0; md_done = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 0;
    idle();
    cyc();
    rst = 1;
  endtask

  initial begin
    // T1: reset with every input high
    rst = 0;
    imem_wait = 1; dmem_wait = 1; E_mispredict = 1;
    E_redirect_pc = '1; E_is_load = 1; E_rd = '1;
    D_rs1 = '1; D_rs2 = '1; D_uses_rs1 = 1; D_uses_rs2 = 1;
    E_md_start = 1; md_done = 1;
    #2;
    chk("rst_ctl", ctl, 8'h00);
    chk("rst_rpc", redirect_pc, 0);
    cyc(); cyc();
    chk("rst_ctl_clk", ctl, 8'h00);
    chk("rst_state", ctrl_state, 0);
    chk("rst_scnt", perf_stall_cnt, 0);
    chk("rst_fcnt", perf_flush_cnt, 0);
    chk("rst_sat_ctl", {s_pc_stall, s_fd_flush, s_redirect_valid}, 0);
    rst = 1;
    idle();
    #1;
    chk("rel_state", ctrl_state, 0);
    chk("rel_ctl", ctl, 8'h00);

    // T2: load-use
    cyc(); E_is_load = 1; E_rd = 5; D_rs2 = 5; D_uses_rs2 = 1; #1;
    chk("lu_rs2", ctl, 8'hC8);
    cyc(); idle(); #1;
    chk("lu_gone", ctl, 8'h00);
    chk("lu_scnt", perf_stall_cnt, 1);
    cyc(); E_is_load = 1; E_rd = 0; D_rs2 = 0; D_uses_rs2 = 1; #1;
    chk("lu_x0", ctl, 8'h00);
    cyc(); idle(); E_is_load = 1; E_rd = 7; D_rs1 = 7; #1;
    chk("lu_nouse", ctl, 8'h00);
    cyc(); D_uses_rs1 = 1; #1;
    chk("lu_rs1", ctl, 8'hC8);
    cyc(); idle(); #1;
    chk("lu_scnt2", perf_stall_cnt, 2);

    // T3: mispredict while fetch busy
    do_reset();
    idle(); E_mispredict = 1; E_redirect_pc = 32'h100; imem_wait = 1; #1;
    chk("mp_ctl", ctl, 8'h29);
    chk("mp_rpc", redirect_pc, 32'h100);
    for (int i = 0; i < 3; i++) begin
      cyc(); E_mispredict = 0; E_redirect_pc = 32'hDEADBEEF; #1;
      chk("rd_state", ctrl_state, 1);
      chk("rd_ctl", ctl, 8'h21);
      chk("rd_rpc", redirect_pc, 32'h100);
    end
    cyc(); imem_wait = 0; #1;
    chk("rd_acc_ctl", ctl, 8'h21);
    chk("rd_acc_rpc", redirect_pc, 32'h100);
    cyc(); idle(); #1;
    chk("rd_run", ctrl_state, 0);
    chk("rd_ctl0", ctl, 8'h00);
    chk("rd_rpc0", redirect_pc, 0);
    chk("rd_fcnt", perf_flush_cnt, 1);
    chk("rd_scnt", perf_stall_cnt, 0);
    E_mispredict = 1; E_redirect_pc = 32'h140; imem_wait = 1; #1;
    chk("mp2_rpc", redirect_pc, 32'h140);
    cyc(); E_redirect_pc = 32'h200; #1;
    chk("rd2_state", ctrl_state, 1);
    chk("rd2_repl", redirect_pc, 32'h200);
    cyc(); E_mispredict = 0; E_redirect_pc = 0; dmem_wait = 1; #1;
    chk("rd2_hold", redirect_pc, 32'h200);
    chk("rd2_dmem", ctl, 8'h35);
    chk("rd2_fcnt", perf_flush_cnt, 2);
    cyc(); idle(); #1;
    chk("rd2_acc", ctl, 8'h21);
    cyc(); #1;
    chk("rd2_run", ctrl_state, 0);

    // T4: priority
    do_reset();
    idle(); dmem_wait = 1; E_mispredict = 1; E_redirect_pc = 32'h300; #1;
    chk("pr_dmem", ctl, 8'hD4);
    chk("pr_norpc", redirect_pc, 0);
    cyc(); dmem_wait = 0; #1;
    chk("pr_redir", ctl, 8'h29);
    chk("pr_rpc", redirect_pc, 32'h300);
    chk("pr_scnt", perf_stall_cnt, 1);
    cyc(); idle(); imem_wait = 1; #1;
    chk("pr_imem", ctl, 8'hA0);
    chk("pr_fcnt", perf_flush_cnt, 1);
    chk("pr_state", ctrl_state, 0);
    cyc(); idle(); E_md_start = 1; md_done = 1; #1;
    chk("pr_mdfast", ctl, 8'h00);
    cyc(); idle(); E_md_start = 1;
    E_is_load = 1; E_rd = 3; D_rs1 = 3; D_uses_rs1 = 1; #1;
    chk("pr_lu_md", ctl, 8'hC8);
    cyc(); idle(); #1;
    chk("pr_state2", ctrl_state, 0);
    chk("pr_scnt2", perf_stall_cnt, 3);

    // T5: mul/div wait
    do_reset();
    idle(); E_md_start = 1; #1;
    chk("md_start", ctl, 8'hD2);
    cyc(); #1;
    chk("md_state", ctrl_state, 2);
    chk("md_w1", ctl, 8'hD2);
    cyc(); #1;
    chk("md_w2", ctl, 8'hD2);
    cyc(); dmem_wait = 1; #1;
    chk("md_dmem", ctl, 8'hD4);
    cyc(); dmem_wait = 0; md_done = 1; #1;
    chk("md_done", ctl, 8'h00);
    chk("md_done_st", ctrl_state, 2);
    cyc(); idle(); #1;
    chk("md_run", ctrl_state, 0);
    chk("md_scnt", perf_stall_cnt, 4);

    // T6: saturation and reset during MDWAIT
    do_reset();
    idle(); imem_wait = 1;
    for (int i = 0; i < 20; i++) cyc();
    imem_wait = 0; #1;
    chk("sat_wide", perf_stall_cnt, 20);
    chk("sat_narrow", s_stall_cnt, 4'hF);
    cyc(); E_md_start = 1; #1;
    cyc(); #1;
    chk("sat_md_state", ctrl_state, 2);
    #2 rst = 0; #1;
    chk("mrst_state", ctrl_state, 0);
    chk("mrst_ctl", ctl, 8'h00);
    chk("mrst_scnt", perf_stall_cnt, 0);
    chk("mrst_sat", s_stall_cnt, 0);
    cyc(); rst = 1; idle(); #1;
    chk("mrst_rel", ctrl_state, 0);
    cyc(); #1;
    chk("mrst_run", ctrl_state, 0);
    chk("mrst_cnt", perf_stall_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
